// File: rtl/sdram_burst_read.sv
// SDRAM burst reader: streams `length` packed words into a FIFO with one READ in flight,
// row-crossing precharge and auto-refresh deferred to group boundaries or idle.
module sdram_burst_read #(
   parameter int unsigned SDRAM_DW = 16,
   parameter int unsigned PACK     = 2,
   parameter int unsigned BANK_W   = 2,
   parameter int unsigned ROW_W    = 12,
   parameter int unsigned COL_W    = 8,
   parameter int unsigned T_RCD    = 2,
   parameter int unsigned T_CAS    = 2,
   parameter int unsigned T_RP     = 2,
   parameter int unsigned T_RFC    = 7,
   parameter int unsigned LEN_W    = 16,
   localparam int unsigned AW      = BANK_W + ROW_W + COL_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [AW-1:0]            address,
   input  logic [LEN_W-1:0]         length,
   output logic                     ready,
   output logic                     done,
   input  logic                     auto_refresh,
   output logic [2:0]               command,
   output logic [ROW_W-1:0]         addr,
   output logic [BANK_W-1:0]        bank,
   output logic [SDRAM_DW/8-1:0]    data_mask,
   input  logic [SDRAM_DW-1:0]      data_in,
   output logic [SDRAM_DW*PACK-1:0] fifo_data,
   output logic                     fifo_wr,
   input  logic                     fifo_full
);

   localparam int unsigned FW = SDRAM_DW * PACK;
   localparam int unsigned CW = 8;

   localparam logic [2:0] CmdNop  = 3'b111;
   localparam logic [2:0] CmdAct  = 3'b011;
   localparam logic [2:0] CmdRead = 3'b101;
   localparam logic [2:0] CmdPre  = 3'b010;
   localparam logic [2:0] CmdAr   = 3'b001;

   typedef enum logic [2:0] {
      StIdle, StActivate, StRead, StCapture, StFifoWait, StPrecharge, StRefresh, StDone
   } state_e;

   // Where a precharge leads once tRP has elapsed.
   typedef enum logic [1:0] {TgtActivate, TgtRefresh, TgtDone} tgt_e;

   state_e           state_q, state_d;
   tgt_e             tgt_q, tgt_d;
   logic             wait_q, wait_d;
   logic [CW-1:0]    cnt_q, cnt_d, wait_len;
   logic [AW-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]       grp_q, grp_d;
   logic [FW-1:0]    data_q, data_d;
   logic             ref_q, ref_d;
   logic             timed, fin, col_wrap;

   logic [COL_W-1:0]  col_f;
   logic [ROW_W-1:0]  row_f;
   logic [BANK_W-1:0] bank_f;

   assign col_f     = addr_q[COL_W-1:0];
   assign row_f     = addr_q[COL_W +: ROW_W];
   assign bank_f    = addr_q[COL_W+ROW_W +: BANK_W];
   assign col_wrap  = (col_f == '0);
   assign data_mask = '0;
   assign fifo_data = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         tgt_q   <= TgtDone;
         wait_q  <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         grp_q   <= '0;
         data_q  <= '0;
         ref_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         grp_q   <= grp_d;
         data_q  <= data_d;
         ref_q   <= ref_d;
      end
   end

   always_comb begin
      wait_len = '0;
      timed    = 1'b1;
      unique case (state_q)
         StActivate:  wait_len = CW'(T_RCD - 1);
         StRead:      wait_len = CW'(T_CAS - 1);
         StPrecharge: wait_len = CW'(T_RP - 1);
         StRefresh:   wait_len = CW'(T_RFC - 1);
         default:     timed = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      len_d   = len_q;
      grp_d   = grp_q;
      data_d  = data_q;
      ref_d   = ref_q | auto_refresh;
      command = CmdNop;
      addr    = '0;
      bank    = '0;
      fifo_wr = 1'b0;
      done    = 1'b0;
      ready   = 1'b0;

      // Timed states issue their command once, then count down wait_len NOP cycles.
      fin = wait_q ? (cnt_q == CW'(1)) : (wait_len == '0);
      if (wait_q) begin
         cnt_d = cnt_q - CW'(1);
         if (fin) wait_d = 1'b0;
      end else if (timed && wait_len != '0) begin
         cnt_d  = wait_len;
         wait_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            ready = !ref_q;
            if (ref_q) begin
               state_d = StPrecharge;
               tgt_d   = TgtRefresh;
            end else if (start) begin
               if (length == '0) begin
                  state_d = StDone;
               end else begin
                  addr_d  = address;
                  len_d   = length;
                  grp_d   = '0;
                  state_d = StActivate;
               end
            end
         end
         StActivate: begin
            if (!wait_q) begin
               command = CmdAct;
               addr    = row_f;
               bank    = bank_f;
            end
            if (fin) state_d = StRead;
         end
         StRead: begin
            if (!wait_q) begin
               command = CmdRead;
               addr    = ROW_W'(col_f);
               bank    = bank_f;
               addr_d  = addr_q + AW'(1);
            end
            if (fin) state_d = StCapture;
         end
         StCapture: begin
            data_d = (data_q << SDRAM_DW) | FW'(data_in);
            if (grp_q == 2'(PACK - 1)) begin
               grp_d   = '0;
               state_d = StFifoWait;
            end else begin
               grp_d = grp_q + 2'd1;
               if (col_wrap) begin
                  state_d = StPrecharge;
                  tgt_d   = TgtActivate;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StFifoWait: begin
            if (!fifo_full) begin
               fifo_wr = 1'b1;
               len_d   = len_q - LEN_W'(1);
               if (len_q == LEN_W'(1)) begin
                  state_d = StPrecharge;
                  tgt_d   = TgtDone;
               end else if (ref_q) begin
                  state_d = StPrecharge;
                  tgt_d   = TgtRefresh;
               end else if (col_wrap) begin
                  state_d = StPrecharge;
                  tgt_d   = TgtActivate;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StPrecharge: begin
            if (!wait_q) begin
               command  = CmdPre;
               addr[10] = 1'b1;
            end
            if (fin) begin
               unique case (tgt_q)
                  TgtActivate: state_d = StActivate;
                  TgtRefresh:  state_d = StRefresh;
                  default:     state_d = StDone;
               endcase
            end
         end
         StRefresh: begin
            if (!wait_q) command = CmdAr;
            if (fin) begin
               ref_d   = 1'b0;
               state_d = (len_q != '0) ? StActivate : StIdle;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: an SDRAM responder plus a transfer-level scoreboard derived
// from start address/length, with directed scenarios and literal expectations.
module tb_sdram_burst_read;

   localparam int unsigned PACK = 2, T_RCD = 2, T_CAS = 2, T_RP = 2, T_RFC = 7;
   localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, PRE = 3'b010, AR = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start, ready, done, auto_refresh, fifo_wr, fifo_full;
   logic [21:0] address;
   logic [15:0] length, data_in;
   logic [2:0]  command;
   logic [11:0] addr;
   logic [1:0]  bank, data_mask;
   logic [31:0] fifo_data;

   logic        start2, ready2, done2, fifo_wr2;
   logic [21:0] address2;
   logic [15:0] length2;
   logic [31:0] data_in2, fifo_data2;
   logic [2:0]  command2;
   logic [11:0] addr2;
   logic [1:0]  bank2;
   logic [3:0]  data_mask2;

   sdram_burst_read u_dut (
      .clk(clk), .rst(rst), .start(start), .address(address), .length(length),
      .ready(ready), .done(done), .auto_refresh(auto_refresh), .command(command),
      .addr(addr), .bank(bank), .data_mask(data_mask), .data_in(data_in),
      .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_full(fifo_full)
   );

   sdram_burst_read #(.SDRAM_DW(32), .PACK(1), .T_CAS(3)) u_dut32 (
      .clk(clk), .rst(rst), .start(start2), .address(address2), .length(length2),
      .ready(ready2), .done(done2), .auto_refresh(1'b0), .command(command2),
      .addr(addr2), .bank(bank2), .data_mask(data_mask2), .data_in(data_in2),
      .fifo_data(fifo_data2), .fifo_wr(fifo_wr2), .fifo_full(1'b0)
   );

   int n_pass = 0, n_tot = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [15:0] f16(input logic [21:0] a);
      return 16'hA000 ^ a[15:0];
   endfunction
   function automatic logic [31:0] f32(input logic [21:0] a);
      return 32'hC0DE0000 ^ 32'(a);
   endfunction

   // SDRAM responder + scoreboard for the default instance
   int          reads = 0, wrs = 0, acts = 0, ars = 0, dones = 0, ars_l = 0, s;
   int          last_act = -100, last_pre = -100, last_ar = -100, last_rd = -100, ar_act_gap = 0;
   logic        open = 1'b0;
   logic [13:0] open_br;
   logic [21:0] exp_rd;
   logic [31:0] w;
   logic [31:0] expq[$];
   logic [31:0] wlog[8];
   logic        sched_v[16];
   logic [15:0] sched_d[16];

   always @(negedge clk) begin : mon
      s = cyc % 16;
      if (sched_v[s] === 1'b1) begin
         data_in = sched_d[s];
         sched_v[s] = 1'b0;
      end else begin
         data_in = 16'hBAD0 ^ 16'(cyc);
      end
      if (rst) begin
         open = 1'b0; reads = 0; wrs = 0; acts = 0;
         expq.delete();
         for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
      end else begin
         if (start && ready) begin
            reads = 0; wrs = 0; acts = 0;
            exp_rd = address;
            for (int k = 0; k < int'(length); k++) begin
               w = '0;
               for (int j = 0; j < int'(PACK); j++) w = {w[15:0], f16(address + 22'(k * PACK + j))};
               expq.push_back(w);
            end
         end
         case (command)
            NOP: ;
            ACT: begin
               chk("act_closed", open, 0);
               chk("act_trp", (cyc - last_pre) >= int'(T_RP), 1);
               chk("act_trfc", (cyc - last_ar) >= int'(T_RFC), 1);
               chk("act_row", {bank, addr}, exp_rd[21:8]);
               open = 1'b1; open_br = {bank, addr}; last_act = cyc; acts++;
               ar_act_gap = cyc - last_ar;
            end
            RD: begin
               chk("rd_open", open, 1);
               chk("rd_trcd", (cyc - last_act) >= int'(T_RCD), 1);
               chk("rd_one_in_flight", (cyc - last_rd) > int'(T_CAS), 1);
               chk("rd_a10", addr[10], 0);
               chk("rd_addr", {bank, open_br[11:0], addr[7:0]}, exp_rd);
               chk("rd_col_hi", addr[11:8], 0);
               sched_v[(cyc + T_CAS) % 16] = 1'b1;
               sched_d[(cyc + T_CAS) % 16] = f16({open_br, addr[7:0]});
               exp_rd = exp_rd + 22'd1; reads++; last_rd = cyc;
            end
            PRE: begin
               chk("pre_a10", addr[10], 1);
               open = 1'b0; last_pre = cyc;
            end
            AR: begin
               chk("ar_closed", open, 0);
               chk("ar_trp", (cyc - last_pre) >= int'(T_RP), 1);
               chk("ar_group_boundary", reads == wrs * int'(PACK), 1);
               ars++; last_ar = cyc;
            end
            default: chk("cmd_legal", command, NOP);
         endcase
         if (fifo_wr) begin
            chk("wr_not_full", fifo_full, 0);
            if (expq.size() == 0) chk("wr_expected", 1, 0);
            else chk("wr_data", fifo_data, expq.pop_front());
            if (wrs < 8) wlog[wrs] = fifo_data;
            wrs++;
         end
         if (done) dones++;
      end
   end

   // Responder for the 32-bit, PACK=1, T_CAS=3 instance
   int          nrd2 = 0, nwr2 = 0, dones2 = 0, s2;
   int          rd_cyc2[4], wr_cyc2[4];
   logic [31:0] wr_val2[4];
   logic [13:0] row2;
   logic        sv2[16];
   logic [31:0] sd2[16];

   always @(negedge clk) begin : mon2
      s2 = cyc % 16;
      if (sv2[s2] === 1'b1) begin
         data_in2 = sd2[s2];
         sv2[s2] = 1'b0;
      end else begin
         data_in2 = 32'hDEAD0000 ^ 32'(cyc);
      end
      if (!rst) begin
         if (command2 == ACT) row2 = {bank2, addr2};
         if (command2 == RD) begin
            if (nrd2 < 4) rd_cyc2[nrd2] = cyc;
            nrd2++;
            sv2[(cyc + 3) % 16] = 1'b1;
            sd2[(cyc + 3) % 16] = f32({row2, addr2[7:0]});
         end
         if (fifo_wr2) begin
            if (nwr2 < 4) begin
               wr_val2[nwr2] = fifo_data2;
               wr_cyc2[nwr2] = cyc;
            end
            nwr2++;
         end
         if (done2) dones2++;
      end
   end

   task automatic launch(input logic [21:0] a, input logic [15:0] len);
      int t = 0;
      @(posedge clk); #1;
      while (ready !== 1'b1 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("ready_wait", ready, 1);
      ars_l = ars;
      start = 1'b1; address = a; length = len;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic xfer_end(input int len, input int exp_ars, input int exp_acts);
      int   t = 0;
      int   d0 = dones;
      logic got = 1'b0;
      while (!got && t < 3000) begin
         @(negedge clk);
         t++;
         if (done === 1'b1) got = 1'b1;
      end
      chk("done_seen", got, 1);
      repeat (2) @(negedge clk);
      chk("done_once", dones - d0, 1);
      chk("wr_count", wrs, len);
      chk("rd_count", reads, len * int'(PACK));
      chk("queue_empty", expq.size(), 0);
      chk("ar_count", ars - ars_l, exp_ars);
      chk("act_count", acts, exp_acts);
   endtask

   task automatic wait_reads(input int n);
      int t = 0;
      while (reads < n && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("reads_reached", reads >= n, 1);
   endtask

   initial begin
      int   t, d0, ars0;
      logic nop_ok;
      start = 0; address = '0; length = '0; auto_refresh = 0; fifo_full = 0;
      start2 = 0; address2 = '0; length2 = '0;

      repeat (2) @(negedge clk);
      chk("rst_cmd_nop", command, NOP);
      chk("rst_no_wr", fifo_wr, 0);
      chk("rst_no_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", ready, 1);
      chk("post_rst_addr", addr, 0);
      chk("post_rst_bank", bank, 0);
      chk("post_rst_fifo_data", fifo_data, 0);
      chk("data_mask_zero", data_mask, 0);

      // 32-bit words, no packing, CAS latency 3
      @(posedge clk); #1;
      start2 = 1'b1; address2 = 22'h50; length2 = 16'd2;
      @(posedge clk); #1;
      start2 = 1'b0;
      t = 0;
      while (dones2 == 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("b_done", dones2, 1);
      chk("b_wr_count", nwr2, 2);
      chk("b_w0", wr_val2[0], 32'hC0DE0050);
      chk("b_w1", wr_val2[1], 32'hC0DE0051);
      chk("b_wr_after_rd0", wr_cyc2[0] - rd_cyc2[0], 4);
      chk("b_wr_after_rd1", wr_cyc2[1] - rd_cyc2[1], 4);

      // Basic three-group transfer
      launch(22'h000010, 16'd3);
      xfer_end(3, 0, 1);
      chk("lit_g0", wlog[0], 32'hA010A011);
      chk("lit_g1", wlog[1], 32'hA012A013);
      chk("lit_g2", wlog[2], 32'hA014A015);

      // Column wrap inside a group
      launch(22'h0000FF, 16'd1);
      xfer_end(1, 0, 2);
      chk("lit_wrap", wlog[0], 32'hA0FFA100);

      // FIFO back-pressure at the first group end
      launch(22'h000020, 16'd2);
      wait_reads(2);
      fifo_full = 1'b1;
      nop_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (command !== NOP || fifo_wr !== 1'b0) nop_ok = 1'b0;
      end
      chk("full_only_nops", nop_ok, 1);
      chk("full_no_wr", wrs, 0);
      @(posedge clk); #1;
      fifo_full = 1'b0;
      xfer_end(2, 0, 1);
      chk("lit_full", wlog[0], 32'hA020A021);

      // Refresh mid-group, plus a start that must be ignored while busy
      launch(22'h000030, 16'd3);
      wait_reads(1);
      auto_refresh = 1'b1; start = 1'b1; address = 22'h003000; length = 16'd5;
      @(posedge clk); #1;
      auto_refresh = 1'b0; start = 1'b0;
      xfer_end(3, 1, 2);
      chk("ar_to_act_gap", ar_act_gap, 7);
      chk("lit_refresh", wlog[1], 32'hA032A033);

      // Zero length: done next cycle, no command
      launch(22'h000077, 16'd0);
      @(negedge clk);
      chk("len0_done", done, 1);
      chk("len0_nop", command, NOP);
      @(negedge clk);
      chk("len0_done_once", done, 0);
      chk("len0_no_reads", reads, 0);

      // Reset mid-transfer, then refresh in idle ahead of a new transfer
      launch(22'h000040, 16'd4);
      wait_reads(3);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      d0 = dones;
      @(negedge clk);
      chk("ready_after_abort", ready, 1);
      @(posedge clk); #1;
      ars0 = ars;
      auto_refresh = 1'b1;
      @(posedge clk); #1;
      auto_refresh = 1'b0;
      start = 1'b1; address = 22'h000300; length = 16'd1;
      @(negedge clk);
      chk("ready_low_ref_pending", ready, 0);
      @(posedge clk); #1;
      start = 1'b0;
      launch(22'h000080, 16'd2);
      chk("idle_refresh_first", ars - ars0, 1);
      xfer_end(2, 0, 1);
      chk("abort_no_done", dones - d0, 1);
      chk("lit_after_abort", wlog[0], 32'hA080A081);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/sdram_burst_read.md
SDRAM_BURST_READ -- requirements
Module: sdram_burst_read

Interface
REQ-001 SHALL have parameter SDRAM_DW, default 16, SDRAM data bus width.
REQ-002 SHALL have parameter PACK, default 2, SDRAM words packed per FIFO word, range 1..4.
REQ-003 SHALL have parameters BANK_W/ROW_W/COL_W, defaults 2/12/8, address field widths; AW = BANK_W+ROW_W+COL_W.
REQ-004 SHALL have parameters T_RCD/T_CAS/T_RP/T_RFC, defaults 2/2/2/7, timing in clk cycles, each >= 1.
REQ-005 SHALL have parameter LEN_W, default 16, width of the transfer length.
REQ-006 Ports SHALL be:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request, accepted only when ready=1
- address  in  AW  start address {bank,row,col} in SDRAM words
- length  in  LEN_W  number of FIFO words to read; 0 means no-op
- ready  out  1  idle, no refresh pending
- done  out  1  one-cycle pulse when the transfer completes
- auto_refresh  in  1  one-cycle refresh request
- command  out  3  {ras_n,cas_n,we_n}: NOP=111, ACT=011, READ=101, PRE=010, AR=001
- addr  out  ROW_W  SDRAM address bus
- bank  out  BANK_W  SDRAM bank select
- data_mask  out  SDRAM_DW/8  constant 0
- data_in  in  SDRAM_DW  SDRAM read data
- fifo_data  out  SDRAM_DW*PACK  packed read word
- fifo_wr  out  1  one-cycle write strobe
- fifo_full  in  1  FIFO cannot accept a word

Function
REQ-007 States SHALL be IDLE, ACTIVATE, READ, CAPTURE, FIFO_WAIT, PRECHARGE, REFRESH, DONE; wait counts SHALL use one shared down-counter, with command=NOP on every counting cycle.
REQ-008 In IDLE, start with ready=1 and length>0 SHALL latch address and length and go to ACTIVATE; start with length=0 SHALL pulse done the next cycle and issue no command.
REQ-009 ACTIVATE SHALL drive ACT, addr=row, bank=bank for one cycle, then wait T_RCD-1 cycles before READ.
REQ-010 READ SHALL drive READ, addr = column zero-extended to ROW_W with bit 10 = 0 (no auto-precharge); data_in SHALL be sampled exactly T_CAS cycles after the READ cycle (CAPTURE); one READ in flight at a time.
REQ-011 Packing: the first captured word of a group SHALL go to the most significant SDRAM_DW bits of fifo_data, the last to the least significant.
REQ-012 fifo_wr SHALL pulse on the cycle after the last word of a group is captured if fifo_full=0; otherwise the FSM SHALL enter FIFO_WAIT, hold fifo_data, and pulse fifo_wr on the first cycle fifo_full=0, with no SDRAM command other than NOP meanwhile.
REQ-013 The word address SHALL increment by 1 after each READ; a column wrap (all-ones to 0) SHALL carry into row, row wrap into bank, bank wrap to address 0.
REQ-014 At a column wrap with words remaining, the FSM SHALL PRECHARGE (addr[10]=1, all banks), wait T_RP-1 cycles, then ACTIVATE the new row.
REQ-015 auto_refresh SHALL be latched in any state, including during reset release and IDLE; a second pulse while one is pending SHALL be absorbed.
REQ-016 A pending refresh SHALL be serviced only at a group boundary (after fifo_wr) or in IDLE: PRECHARGE all, wait T_RP-1, AR, wait T_RFC-1, clear pending, then ACTIVATE the current address if words remain, else return to IDLE.
REQ-017 In IDLE, a pending refresh SHALL take priority over start; ready SHALL be 0 while refresh is pending or in progress.
REQ-018 After the final fifo_wr, the FSM SHALL PRECHARGE all, wait T_RP-1, pulse done for one cycle (DONE state), and return to IDLE.
REQ-019 start asserted while ready=0 SHALL be ignored.

Reset
REQ-020 On rst=1, the FSM SHALL enter IDLE, with command=NOP, addr=0, bank=0, fifo_data=0, fifo_wr=0, done=0, refresh pending cleared, counters 0; ready=1 on the first cycle after rst deasserts.
REQ-021 rst asserted mid-transfer SHALL abandon the transfer with no further fifo_wr or done.

Verification
REQ-022 Defaults, address=0x000010, length=3, fifo_full=0 -> ACT row0 bank0, 6 READs cols 0x10..0x15, 3 fifo_wr with {w0,w1},{w2,w3},{w4,w5}, PRE, done once.
REQ-023 address=0x0000FF, length=1 -> READ col 0xFF, PRE, ACT row1, READ col 0x00, fifo_wr={d(0xFF),d(0x100)}.
REQ-024 fifo_full=1 for 10 cycles at the first group end -> only NOPs for those cycles, a single fifo_wr on release, data unchanged.
REQ-025 auto_refresh pulse mid-group -> group completes, then PRE, AR, T_RFC-1 NOPs, ACT of the same row, transfer continues with no lost or duplicated word.
REQ-026 PACK=1, SDRAM_DW=32, T_CAS=3, length=2 -> 2 fifo_wr of 32 bits, each sampled 3 cycles after its READ.
REQ-027 rst mid-transfer, then auto_refresh in IDLE followed by start -> refresh sequence first, then the transfer; no fifo_wr from the aborted transfer.
